// File: rtl/exec_pkg.sv
// Shared encodings for the MIPS execute unit.
// ALU_NOR is decoded only when EXEC_ALU_NOR_EN is defined.
package exec_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_NOR = 3'b100;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;

  localparam logic [1:0] OP_MEM  = 2'b00;
  localparam logic [1:0] OP_BEQ  = 2'b01;
  localparam logic [1:0] OP_RTYP = 2'b10;
  localparam logic [1:0] OP_IMM  = 2'b11;

endpackage

// File: rtl/exec_alu_ctrl.sv
// aluop/funct to alu_ctl decoder.
// NOR decode depends on EXEC_ALU_NOR_EN.
module exec_alu_ctrl
  import exec_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [2:0] alu_ctl
);

  logic [2:0] fn_ctl;

  always_comb begin
    fn_ctl = ALU_ADD;
    unique case (1'b1)
      (funct == F_ADD): fn_ctl = ALU_ADD;
      (funct == F_SUB): fn_ctl = ALU_SUB;
      (funct == F_AND): fn_ctl = ALU_AND;
      (funct == F_OR):  fn_ctl = ALU_OR;
      (funct == F_SLT): fn_ctl = ALU_SLT;
`ifdef EXEC_ALU_NOR_EN
      (funct == F_NOR): fn_ctl = ALU_NOR;
`endif
      default:          fn_ctl = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_ctl = ALU_ADD;
    unique case (aluop)
      OP_MEM:  alu_ctl = ALU_ADD;
      OP_BEQ:  alu_ctl = ALU_SUB;
      OP_RTYP: alu_ctl = fn_ctl;
      OP_IMM:  alu_ctl = ALU_ADD;
      default: alu_ctl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_exec_unit.sv
// Execute stage: ALU control, ALU, PC adders, N/Z/V flags.
// Optional NOR op enabled by EXEC_ALU_NOR_EN.
module mips_exec_unit
  import exec_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  aluop,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [31:0] imm_sext,
  input  logic        flag_we,
  output logic [2:0]  alu_ctl,
  output logic [31:0] result,
  output logic        zero,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target,
  output logic        flag_n,
  output logic        flag_z,
  output logic        flag_v
);

  logic [31:0] sum;
  logic [31:0] diff;
  logic        slt;
  logic        v;

  exec_alu_ctrl u_ctrl (
    .aluop   (aluop),
    .funct   (funct),
    .alu_ctl (alu_ctl)
  );

  assign sum  = a + b;
  assign diff = a - b;
  assign slt  = $signed(a) < $signed(b);

  always_comb begin
    result = '0;
    v      = 1'b0;
    unique case (alu_ctl)
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      ALU_ADD: begin
        result = sum;
        v = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      ALU_SUB: begin
        result = diff;
        v = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      ALU_SLT: result = {31'b0, slt};
`ifdef EXEC_ALU_NOR_EN
      ALU_NOR: result = ~(a | b);
`endif
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);

  assign pc_plus4      = pc + 32'd4;
  assign branch_target = pc_plus4 + (imm_sext << 2);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_n <= 1'b0;
      flag_z <= 1'b0;
      flag_v <= 1'b0;
    end else if (flag_we) begin
      flag_n <= result[31];
      flag_z <= zero;
      flag_v <= v;
    end
  end

endmodule

// File: tb/tb_mips_exec_unit.sv
// Directed bench for mips_exec_unit.
// Expected values are hand-computed constants.
module tb_mips_exec_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] a, b, pc, imm_sext;
  logic        flag_we;
  logic [2:0]  alu_ctl;
  logic [31:0] result, pc_plus4, branch_target;
  logic        zero, flag_n, flag_z, flag_v;

  int total = 0;
  int bad = 0;

  mips_exec_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .aluop         (aluop),
    .funct         (funct),
    .a             (a),
    .b             (b),
    .pc            (pc),
    .imm_sext      (imm_sext),
    .flag_we       (flag_we),
    .alu_ctl       (alu_ctl),
    .result        (result),
    .zero          (zero),
    .pc_plus4      (pc_plus4),
    .branch_target (branch_target),
    .flag_n        (flag_n),
    .flag_z        (flag_z),
    .flag_v        (flag_v)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic flags(input string tag, input logic n,
                       input logic z, input logic vv);
    chk({tag, "_n"}, {31'b0, flag_n}, {31'b0, n});
    chk({tag, "_z"}, {31'b0, flag_z}, {31'b0, z});
    chk({tag, "_v"}, {31'b0, flag_v}, {31'b0, vv});
  endtask

  task automatic drive(input logic [1:0] op, input logic [5:0] f,
                       input logic [31:0] aa, input logic [31:0] bb);
    aluop = op;
    funct = f;
    a = aa;
    b = bb;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    flag_we = 1'b0;
    pc = 32'h0;
    imm_sext = 32'h0;
    drive(2'b00, 6'h0, 32'h0, 32'h0);
    #2;
    flags("rst", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    flag_we = 1'b1;

    drive(2'b10, 6'b100000, 32'd7, 32'd5);
    chk("add_ctl", {29'b0, alu_ctl}, 32'd2);
    chk("add_res", result, 32'd12);
    chk("add_zero", {31'b0, zero}, 32'd0);
    tick;
    flags("add_f", 1'b0, 1'b0, 1'b0);

    drive(2'b01, 6'h0, 32'h1234, 32'h1234);
    chk("beq_ctl", {29'b0, alu_ctl}, 32'd6);
    chk("beq_res", result, 32'd0);
    chk("beq_zero", {31'b0, zero}, 32'd1);
    chk("beq_zpre", {31'b0, flag_z}, 32'd0);
    tick;
    flags("beq_f", 1'b0, 1'b1, 1'b0);

    drive(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1);
    chk("ovf_res", result, 32'h80000000);
    tick;
    flags("ovf_f", 1'b1, 1'b0, 1'b1);

    flag_we = 1'b0;
    drive(2'b10, 6'b100000, 32'h0, 32'h0);
    chk("hold_zero", {31'b0, zero}, 32'd1);
    tick;
    flags("hold_f", 1'b1, 1'b0, 1'b1);
    flag_we = 1'b1;

    drive(2'b10, 6'b100010, 32'h80000000, 32'h1);
    chk("subv_ctl", {29'b0, alu_ctl}, 32'd6);
    chk("subv_res", result, 32'h7FFFFFFF);
    tick;
    flags("subv_f", 1'b0, 1'b0, 1'b1);

    drive(2'b10, 6'b101010, 32'hFFFFFFFF, 32'h1);
    chk("slt1_ctl", {29'b0, alu_ctl}, 32'd7);
    chk("slt1_res", result, 32'd1);
    tick;
    flags("slt1_f", 1'b0, 1'b0, 1'b0);
    drive(2'b10, 6'b101010, 32'h1, 32'hFFFFFFFF);
    chk("slt0_res", result, 32'd0);
    chk("slt0_zero", {31'b0, zero}, 32'd1);

    drive(2'b10, 6'b100100, 32'hF0F000FF, 32'h0FF00F0F);
    chk("and_ctl", {29'b0, alu_ctl}, 32'd0);
    chk("and_res", result, 32'h00F0000F);
    drive(2'b10, 6'b100101, 32'hF0F000FF, 32'h0FF00F0F);
    chk("or_ctl", {29'b0, alu_ctl}, 32'd1);
    chk("or_res", result, 32'hFFF00FFF);

    drive(2'b00, 6'b100010, 32'h10, 32'h20);
    chk("mem_ctl", {29'b0, alu_ctl}, 32'd2);
    chk("mem_res", result, 32'h30);
    drive(2'b11, 6'b100010, 32'h10, 32'h20);
    chk("imm_ctl", {29'b0, alu_ctl}, 32'd2);
    drive(2'b10, 6'b000000, 32'h10, 32'h20);
    chk("unk_ctl", {29'b0, alu_ctl}, 32'd2);
    chk("unk_res", result, 32'h30);

    drive(2'b10, 6'b100111, 32'hF0F00000, 32'h0F000000);
`ifdef EXEC_ALU_NOR_EN
    chk("nor_ctl", {29'b0, alu_ctl}, 32'd4);
    chk("nor_res", result, 32'h000FFFFF);
`else
    chk("nor_ctl", {29'b0, alu_ctl}, 32'd2);
    chk("nor_res", result, 32'hFFF00000);
`endif

    pc = 32'h10;
    imm_sext = 32'hFFFFFFFE;
    #1;
    chk("pc4", pc_plus4, 32'h14);
    chk("bt", branch_target, 32'hC);
    pc = 32'hFFFFFFFC;
    imm_sext = 32'h40000001;
    #1;
    chk("pc4_wrap", pc_plus4, 32'h0);
    chk("bt_drop", branch_target, 32'h4);

    drive(2'b10, 6'b100000, 32'h7FFFFFFF, 32'h1);
    tick;
    flags("pre_rst", 1'b1, 1'b0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    flags("mid_rst", 1'b0, 1'b0, 1'b0);
    chk("rst_res", result, 32'h80000000);
    tick;
    flags("rst_hold", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    flags("post_rst", 1'b1, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
